// File: rtl/ram_burst_master.sv
`default_nettype none
// ----------------------------------------------------------------------
// ram_burst_master : burst read/write sequencer for a 1-cycle-latency RAM
// Revision 1.0
// ----------------------------------------------------------------------
module ram_burst_master #(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [a_width-1:0] cmd_addr,
  input  logic [a_width-1:0] cmd_len,
  input  logic [d_width-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [d_width-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               busy,
  output logic               ram_we,
  output logic [a_width-1:0] ram_address,
  output logic [d_width-1:0] ram_data_in,
  input  logic [d_width-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [a_width-1:0] ONE_A = {{(a_width-1){1'b0}}, 1'b1};

  state_t             state;
  logic [a_width-1:0] addr_cnt;
  logic [a_width-1:0] remaining;
  logic [d_width-1:0] rbuf [2];
  logic               head;
  logic [1:0]         occ;
  logic               inflight;

  logic pop;
  logic issue;
  logic wr_beat;
  logic wptr;

  assign rd_valid    = (occ != 2'd0);
  assign rd_data     = rbuf[head];
  assign pop         = rd_valid && rd_ready;
  assign wr_beat     = (state == WRITE) && wr_valid;
  assign ram_we      = wr_beat;
  assign ram_data_in = wr_data;
  assign ram_address = addr_cnt;
  // Tail slot is head + occ (mod 2); occ never reaches 2 while a word is in flight.
  assign wptr        = head ^ occ[0];
  assign issue       = (state == READ) &&
                       (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      rbuf[0]   <= '0;
      rbuf[1]   <= '0;
      head      <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) rbuf[wptr] <= ram_data_out;
      if (pop) head <= ~head;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_cnt  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_write ? WRITE : READ;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wr_ready  <= cmd_write;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            addr_cnt  <= addr_cnt + ONE_A;
            remaining <= remaining - ONE_A;
            if (remaining == '0) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              wr_ready  <= 1'b0;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_cnt  <= addr_cnt + ONE_A;
            remaining <= remaining - ONE_A;
            if (remaining == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the final word is popped so busy drops right after it.
          if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_ram_burst_master : self-checking bench with RAM model and memory reference
// Revision 1.0
// ----------------------------------------------------------------------
module tb_ram_burst_master;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready = 1'b0, busy, ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;

  always #5 clk = ~clk;

  ram_burst_master #(.d_width(DW), .a_width(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .ram_we(ram_we), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Synchronous RAM with registered read output.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_address] <= ram_data_in;
    ram_data_out <= ram[ram_address];
  end

  // Reference memory image, updated per write word in address order.
  logic [DW-1:0] model [256];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0: always 1, 1: 1,0,1,1,0,1..., 2: 1,0,0,1,0,1..., 3: 75% random, 4: 50% random
  function automatic logic pat(input int mode, input int t);
    logic [5:0] p;
    case (mode)
      0: return 1'b1;
      1: begin p = 6'b101101; return p[t % 6]; end
      2: begin p = 6'b101001; return p[t % 6]; end
      3: return ($urandom_range(0, 3) != 0);
      default: return ($urandom_range(0, 1) != 0);
    endcase
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input logic [DW-1:0] words[$], input int wmode);
    int n = int'(len) + 1;
    int k = 0;
    int t = 0;
    int guard = 0;
    logic wv;
    logic first = 1'b1;
    logic [AW-1:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len; wr_valid = 1'b0;
    #1 check("wr_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
    while (k < n && guard < 2000) begin
      if (!first) @(negedge clk);
      wv = pat(wmode, t);
      t++;
      wr_valid = wv;
      wr_data  = wv ? words[k] : DW'($urandom);
      #1;
      if (first) begin
        check("wr_busy", busy, 1);
        check("wr_first_addr", ram_address, addr);
        first = 1'b0;
      end
      if (wv) begin
        check("wr_ready", wr_ready, 1);
        if (wr_ready) begin
          ea = addr + AW'(k);
          check("wr_we", ram_we, 1);
          check("wr_addr", ram_address, ea);
          check("wr_din", ram_data_in, words[k]);
          model[ea] = words[k];
          k++;
        end
      end else begin
        check("wr_gap_we", ram_we, 0);
      end
      guard++;
    end
    check("wr_beats", k, n);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("wr_done_cmd_ready", cmd_ready, 1);
    check("wr_done_busy", busy, 0);
    check("wr_done_we", ram_we, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                         input logic [DW-1:0] exp[$], input int rmode);
    int n = int'(len) + 1;
    int popped = 0;
    int issued = 0;
    int max_ahead = 0;
    int c_acc;
    int guard = 0;
    int t = 0;
    int busy_fall = -1;
    logic [AW-1:0] prev_addr = '0;
    logic prev_rd_phase = 1'b0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1 check("rd_cmd_ready", cmd_ready, 1);
    c_acc = cyc;
    while ((popped < n || busy) && guard < 3000) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
      rd_ready = pat(rmode, t);
      t++;
      #1;
      if (cyc == c_acc + 1) begin
        check("rd_busy", busy, 1);
        check("rd_first_addr", ram_address, addr);
      end
      if (prev_rd_phase && ram_address != prev_addr) issued++;
      if (issued - popped > max_ahead) max_ahead = issued - popped;
      if (stalled) begin
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_data", rd_data, held);
      end
      if (rd_valid && rd_ready) begin
        if (popped < n) begin
          check("rd_data", rd_data, exp[popped]);
          if (rmode == 0) check("rd_pop_cycle", cyc, c_acc + 3 + popped);
        end else begin
          check("rd_extra_word", popped + 1, n);
        end
        popped++;
      end
      if (!busy && busy_fall < 0 && cyc > c_acc) busy_fall = cyc;
      stalled       = rd_valid && !rd_ready;
      held          = rd_data;
      prev_rd_phase = busy && !wr_ready;
      prev_addr     = ram_address;
      guard++;
    end
    check("rd_word_count", popped, n);
    check("rd_ahead_le2", (max_ahead <= 2) ? 1 : 0, 1);
    check("rd_done_valid", rd_valid, 0);
    if (rmode == 0) check("rd_idle_cycle", busy_fall, c_acc + n + 3);
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int            mode;
    logic [DW-1:0] exp [4];
  } vec_t;

  vec_t vecs [7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q[$];
    for (int i = 0; i < 256; i++) begin
      ram[i]   = '0;
      model[i] = '0;
    end

    vecs[0] = '{1'b1, 8'h10, 8'd3, 8'hA0, 8'h01, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{1'b0, 8'h10, 8'd3, 8'h00, 8'h00, 0, '{8'hA0, 8'hA1, 8'hA2, 8'hA3}};
    vecs[2] = '{1'b0, 8'h10, 8'd3, 8'h00, 8'h00, 2, '{8'hA0, 8'hA1, 8'hA2, 8'hA3}};
    vecs[3] = '{1'b1, 8'hFE, 8'd3, 8'h11, 8'h11, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{1'b0, 8'hFE, 8'd3, 8'h00, 8'h00, 0, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vecs[5] = '{1'b1, 8'h40, 8'd3, 8'h55, 8'h01, 1, '{8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{1'b0, 8'h40, 8'd3, 8'h00, 8'h00, 2, '{8'h55, 8'h56, 8'h57, 8'h58}};

    // Reset state
    @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_address", ram_address, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    #1 check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed table
    for (int v = 0; v < 7; v++) begin
      q.delete();
      if (vecs[v].wr) begin
        for (int i = 0; i <= int'(vecs[v].len); i++)
          q.push_back(vecs[v].base + DW'(i) * vecs[v].step);
        do_write(vecs[v].addr, vecs[v].len, q, vecs[v].mode);
      end else begin
        for (int i = 0; i < 4; i++) q.push_back(vecs[v].exp[i]);
        do_read(vecs[v].addr, vecs[v].len, q, vecs[v].mode);
      end
    end

    // Reset with two words buffered under backpressure
    q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    do_write(8'h80, 8'd3, q, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h80; cmd_len = 8'd3; rd_ready = 1'b0;
    #1 check("rr_cmd_ready", cmd_ready, 1);
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #1;
    check("rr_pre_valid", rd_valid, 1);
    check("rr_pre_data", rd_data, 8'hC0);
    rst = 1'b1;
    #1;
    check("rr_rd_valid", rd_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_cmd_ready", cmd_ready, 0);
    check("rr_rd_data", rd_data, 0);
    check("rr_address", ram_address, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("rr_post_cmd_ready", cmd_ready, 1);
    do_read(8'h80, 8'd3, q, 0);

    // Randomized bursts against the reference memory
    for (int it = 0; it < 16; it++) begin
      logic [AW-1:0] a, l, a2, l2;
      logic [DW-1:0] e[$];
      int rm;
      a  = AW'($urandom);
      l  = (it == 3) ? 8'd0 : AW'($urandom_range(0, 12));
      q.delete();
      for (int i = 0; i <= int'(l); i++) q.push_back(DW'($urandom));
      do_write(a, l, q, 3);
      a2 = a + AW'($urandom_range(0, 3));
      l2 = (it == 5) ? 8'd0 : AW'($urandom_range(0, 12));
      e.delete();
      for (int i = 0; i <= int'(l2); i++) e.push_back(model[a2 + AW'(i)]);
      rm = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 2 : 4);
      do_read(a2, l2, e, rm);
    end

    // Whole-RAM burst with wraparound
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(DW'($urandom));
    do_write(8'h37, 8'hFF, q, 3);
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(model[8'h37 + AW'(i)]);
    do_read(8'h37, 8'hFF, q, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
